// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {pc, instr} pairs
// with a valid/ready handshake on both sides and a single-cycle flush from EX.
module fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;

  // Empty head reads as pc=0 / sll $0,$0,0 so decode never sees stale storage.
  function automatic logic [ADDR_W-1:0] nop_pc(input logic vld, input logic [ADDR_W-1:0] pc);
    return vld ? pc : '0;
  endfunction

  function automatic logic [INSTR_W-1:0] nop_instr(input logic vld, input logic [INSTR_W-1:0] ins);
    return vld ? ins : '0;
  endfunction

  // Handshake flags come from registered count only, so in_ready never depends on out_ready.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_pc    = nop_pc(out_valid, pc_mem[rd_ptr]);
  assign out_instr = nop_instr(out_valid, instr_mem[rd_ptr]);

  // Storage is data-only: written on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO's observable behaviour.
module tb_fetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_pc = '0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W+INSTR_W-1:0] mq [$];

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_state(input string tag);
    logic [ADDR_W-1:0]  e_pc;
    logic [INSTR_W-1:0] e_ins;
    e_pc  = '0;
    e_ins = '0;
    if (mq.size() != 0) begin
      e_pc  = mq[0][ADDR_W+INSTR_W-1:INSTR_W];
      e_ins = mq[0][INSTR_W-1:0];
    end
    check({tag, ".count"},     64'(count),     64'(mq.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
    check({tag, ".out_pc"},    64'(out_pc),    64'(e_pc));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(e_ins));
  endtask

  // Drive one cycle's inputs, advance one edge, update the model, check after the edge.
  task automatic cycle(input string tag, input logic v, input logic [ADDR_W-1:0] pc,
                       input logic [INSTR_W-1:0] ins, input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = ordy && (mq.size() > 0) && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, observed while rst is still held
    #3;
    check_state("reset");
    check("reset.out_pc", 64'(out_pc), 64'h0);
    #4 rst = 1'b0;

    // 1: single push, then drain
    cycle("t1.push", 1'b1, 32'h4, 32'h2008_0005, 1'b1, 1'b0);
    check("t1.pc", 64'(out_pc), 64'h4);
    check("t1.instr", 64'(out_instr), 64'h2008_0005);
    cycle("t1.drain", 1'b0, 32'hdead_beef, 32'hdead_beef, 1'b1, 1'b0);
    check("t1.empty_pc", 64'(out_pc), 64'h0);

    // 2: fill while decode stalls, refuse a fifth push, drain in order
    for (int i = 1; i <= 4; i++)
      cycle("t2.fill", 1'b1, ADDR_W'(4*i), INSTR_W'(32'h1000 + i), 1'b0, 1'b0);
    check("t2.count", 64'(count), 64'd4);
    check("t2.in_ready", 64'(in_ready), 64'd0);
    cycle("t2.refuse", 1'b1, 32'h14, 32'h1005, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("t2.order", 64'(out_pc), 64'(4*i));
      cycle("t2.drain", 1'b0, '0, '0, 1'b1, 1'b0);
    end
    check("t2.empty", 64'(out_valid), 64'd0);

    // 3: streaming, pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      cycle("t3.stream", 1'b1, ADDR_W'(32'h100 + 4*i), INSTR_W'(32'h3000 + i), 1'b1, 1'b0);
      check("t3.count", 64'(count), 64'd1);
      check("t3.delay", 64'(out_pc), 64'(32'h100 + 4*i));
    end
    cycle("t3.drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // 4: flush with 3 queued and a same-cycle push
    for (int i = 1; i <= 3; i++)
      cycle("t4.fill", 1'b1, ADDR_W'(32'h20 + 4*i), INSTR_W'(i), 1'b0, 1'b0);
    cycle("t4.flush", 1'b1, 32'h30, 32'h30, 1'b1, 1'b1);
    check("t4.count", 64'(count), 64'd0);
    check("t4.in_ready", 64'(in_ready), 64'd1);
    cycle("t4.after", 1'b1, 32'h40, 32'h40, 1'b0, 1'b0);
    check("t4.next_pc", 64'(out_pc), 64'h40);
    cycle("t4.hold_flush", 1'b1, 32'h44, 32'h44, 1'b1, 1'b1);
    cycle("t4.hold_flush", 1'b1, 32'h48, 32'h48, 1'b1, 1'b1);

    // 5: full queue with simultaneous push and pop
    for (int i = 1; i <= 4; i++)
      cycle("t5.fill", 1'b1, ADDR_W'(32'h200 + 4*i), INSTR_W'(i), 1'b0, 1'b0);
    cycle("t5.both", 1'b1, 32'h250, 32'h250, 1'b1, 1'b0);
    check("t5.count3", 64'(count), 64'd3);
    cycle("t5.accept", 1'b1, 32'h250, 32'h250, 1'b0, 1'b0);
    check("t5.count4", 64'(count), 64'd4);
    cycle("t5.clear", 1'b0, '0, '0, 1'b0, 1'b1);

    // 6: asynchronous reset between edges with 2 entries queued
    cycle("t6.fill", 1'b1, 32'h60, 32'h60, 1'b0, 1'b0);
    cycle("t6.fill", 1'b1, 32'h64, 32'h64, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    check_state("t6.async");
    #2 rst = 1'b0;
    cycle("t6.first", 1'b1, 32'h70, 32'h70, 1'b0, 1'b0);
    check("t6.first_pc", 64'(out_pc), 64'h70);
    check("t6.count", 64'(count), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) < 7),
            ADDR_W'($urandom),
            INSTR_W'($urandom),
            ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 99) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
